seq_cla_addsub: RTL

- Parametrised sequential add/subtract unit built on a 4-bit carry-lookahead slice.
- Processes a WIDTH-bit operand pair one 4-bit nibble per clock, LSB nibble first, with a registered inter-slice carry.
- Successor to the fixed 4-bit combinational lookahead adder: arbitrary width, subtract mode, carry-in, and a valid/ready handshake.
- Sits between operand registers and the result/flag consumer in the lab datapath.

---
 rtl/seq_cla_addsub_pkg.sv | 13 +
 rtl/seq_cla_addsub_cla4.sv | 30 +++
 rtl/seq_cla_addsub.sv | 95 +++++++++
 3 files changed

// File: rtl/seq_cla_addsub_pkg.sv
// Shared constants for the sequential lookahead add/subtract unit:
// FSM state encodings and the nibble slice width.
package seq_cla_addsub_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_cla_addsub_cla4.sv
// 4-bit carry-lookahead slice. Each carry is a flat sum of products over
// g/p and cin, so no carry ripples through another carry inside the nibble.
// c3 is the carry into the MSB and is used for signed overflow.
module cla_slice4
  import seq_cla_addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] s,
  output logic               c4,
  output logic               c3
);

  logic [3:0] g, p;
  logic       c1, c2;

  // generate/propagate terms and flat lookahead carries
  always_comb begin
    g  = a & b;
    p  = a ^ b;
    c1 = g[0] | (p[0] & cin);
    c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
       | (p[3] & p[2] & p[1] & p[0] & cin);
    s  = p ^ {c3, c2, c1, cin};
  end

endmodule

// File: rtl/seq_cla_addsub.sv
// Sequential WIDTH-bit add/subtract: one 4-bit lookahead slice reused per
// cycle, LSB nibble first, with a registered carry between nibbles.
// Optional macro SEQ_ADDER_OVF_EN adds the signed-overflow output ovf.
module seq_cla_addsub
  import seq_cla_addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int NSLICE = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SEQ_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t             state;
  logic [CW-1:0]      k;
  logic               carry;
  logic [WIDTH-1:0]   opa, opb;
  logic [SLICE_W-1:0] s_nib;
  logic               c4, c3;
  logic               accept;

  // one lookahead slice, fed the k-th nibble of the latched operands
  cla_slice4 u_slice (
    .a   (opa[k*SLICE_W +: SLICE_W]),
    .b   (opb[k*SLICE_W +: SLICE_W]),
    .cin (carry),
    .s   (s_nib),
    .c4  (c4),
    .c3  (c3)
  );

  // a finished result being drained frees the unit in the same cycle
  always_comb begin
    in_ready  = (state == ST_IDLE) || ((state == ST_DONE) && out_ready);
    out_valid = (state == ST_DONE);
    accept    = in_valid && in_ready;
  end

  // control FSM, operand latch, nibble accumulation and result flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      carry <= 1'b0;
      opa   <= '0;
      opb   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SEQ_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      // subtract = add inverted B with carry-in forced to 1
      opa   <= a;
      opb   <= b ^ {WIDTH{sub}};
      carry <= sub ? 1'b1 : cin;
      k     <= '0;
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          sum[k*SLICE_W +: SLICE_W] <= s_nib;
          carry <= c4;
          k     <= k + 1'b1;
          if (k == CW'(NSLICE - 1)) begin
            cout  <= c4;
`ifdef SEQ_ADDER_OVF_EN
            ovf   <= c3 ^ c4;
`endif
            state <= ST_DONE;
          end
        end
        ST_DONE: if (out_ready) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
